alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter LATENCY, default 1: ALU cycles from operand/select drive to result sample; SHALL be legal for values 1..15.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req0_valid / req1_valid  input  1 each  requester N has an operation pending.
REQ-006 req0_ready / req1_ready  output  1 each  requester N's operation is accepted this cycle.
REQ-007 req0_op / req1_op  input  4 each  ALU select code.
REQ-008 req0_a, req0_b / req1_a, req1_b  input  32 each  operands.
REQ-009 alu_select  output  4  select code to the ALU result mux.
REQ-010 alu_a, alu_b  output  32 each  operands to the ALU.
REQ-011 alu_result  input  32  ALU mux output.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_id  output  1  requester index owning the response.
REQ-015 rsp_data  output  32  result.
REQ-016 rsp_err  output  1  illegal opcode flag.

Function
REQ-017 FSM states SHALL be IDLE, EXEC and RESP; there is exactly one operation in flight.
REQ-018 IDLE: if any reqN_valid is high, grant exactly one requester, assert its reqN_ready combinationally that cycle, capture op/a/b/id, and leave IDLE next cycle.
REQ-019 Tie (both valid): grant the requester not served last; after reset, requester 0 wins the first tie.
REQ-020 A single valid requester SHALL be granted regardless of the round-robin pointer.
REQ-021 reqN_ready SHALL be 0 outside IDLE and for the non-granted requester.
REQ-022 Legal opcodes SHALL be 0,1,2,5,6,7,8,9,11; any other captured op goes IDLE->RESP directly with rsp_err=1, rsp_data=0, and no EXEC cycles.
REQ-023 Legal op: IDLE->EXEC; alu_select/alu_a/alu_b SHALL be driven from the capture registers; a down-counter loaded with LATENCY SHALL decrement each EXEC cycle.
REQ-024 On the EXEC cycle where the counter equals 1, alu_result SHALL be registered into rsp_data with rsp_err=0, and the state SHALL move to RESP; EXEC lasts exactly LATENCY cycles.
REQ-025 RESP: rsp_valid=1; rsp_data/rsp_err/rsp_id SHALL be held stable until rsp_ready=1; on that handshake the state SHALL return to IDLE and the round-robin pointer SHALL update to rsp_id.
REQ-026 rsp_valid SHALL be 0 in IDLE and EXEC.
REQ-027 alu_select/alu_a/alu_b SHALL hold their last captured values outside EXEC, changing only on an IDLE grant.
REQ-028 Minimum issue interval per legal op SHALL be LATENCY+2 cycles with rsp_ready tied high.
REQ-029 reqN_* input changes after acceptance SHALL NOT affect the in-flight operation.

Reset
REQ-030 On rst: state=IDLE, counter=0, req0_ready=req1_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_id=0, alu_select=0, alu_a=alu_b=0, pointer=1 (requester 0 favoured).
REQ-031 Reset asserted in EXEC or RESP SHALL discard the operation; no response SHALL be produced afterwards.
REQ-032 Reset SHALL take priority over all other events in the same cycle.

Structure
REQ-033 Package alu_ctrl_pkg SHALL hold the opcode constants (OP_* for 0,1,2,5,6,7,8,9,11), the FSM state typedef and the is_legal_op function.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter_2 (inputs: two valids, pointer; outputs: one-hot grant).

Verification
REQ-035 LATENCY=1; req0 op=0, a=5, b=3, rsp_ready=1 -> req0_ready in cycle 0, alu_select=0 in cycle 1, rsp_valid cycle 2 with rsp_id=0 and rsp_data=alu_result.
REQ-036 Both valid continuously for 4 ops -> grants 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-037 req1 op=4'b0011 -> rsp_err=1, rsp_data=0, rsp_valid one cycle after grant, alu_select unchanged.
REQ-038 LATENCY=3, rsp_ready low 5 cycles in RESP -> EXEC lasts 3 cycles; rsp_data stable all 5 cycles; no reqN_ready during the stall.
REQ-039 rst pulsed in EXEC -> next cycle all outputs at reset values; no rsp_valid until a new grant.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, FSM state type and opcode legality check
// for the two-requester ALU arbiter.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_SLT = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SRA, OP_SLT: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signals of the ALU arbiter; the arbiter
// is the slave, the requesters/ALU/consumer side is the master.
interface alu_arbiter_if;

  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [3:0]  req0_op;
  logic [3:0]  req1_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  alu_select;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
    input  req0_a, req0_b, req1_a, req1_b, alu_result, rsp_ready,
    output req0_ready, req1_ready, alu_select, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
    output req0_a, req0_b, req1_a, req1_b, alu_result, rsp_ready,
    input  req0_ready, req1_ready, alu_select, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant; ptr_i is the requester served last, so on a
// tie the other one wins. A lone valid is always granted.
module rr_arbiter_2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (valid0_i && valid1_i) begin
      grant_o = ptr_i ? 2'b01 : 2'b10;
    end else if (valid0_i) begin
      grant_o = 2'b01;
    end else if (valid1_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters, one operation in flight,
// with a LATENCY-cycle execute window and a held response.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);

  localparam logic [3:0] LAT_L = 4'(LATENCY);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;
  logic        id_q, id_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic [1:0]  grant;
  logic [3:0]  gnt_op;
  logic [31:0] gnt_a;
  logic [31:0] gnt_b;
  logic        ready0, ready1, rsp_valid;

  rr_arbiter_2 u_rr (
    .valid0_i (bus.req0_valid),
    .valid1_i (bus.req1_valid),
    .ptr_i    (ptr_q),
    .grant_o  (grant)
  );

  assign gnt_op = grant[1] ? bus.req1_op : bus.req0_op;
  assign gnt_a  = grant[1] ? bus.req1_a  : bus.req0_a;
  assign gnt_b  = grant[1] ? bus.req1_b  : bus.req0_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    sel_d     = sel_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    err_d     = err_q;
    ready0    = 1'b0;
    ready1    = 1'b0;
    rsp_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // No acceptance may be signalled while reset is being applied.
        if (!rst && (grant != 2'b00)) begin
          ready0 = grant[0];
          ready1 = grant[1];
          id_d   = grant[1];
          if (is_legal_op(gnt_op)) begin
            sel_d   = gnt_op;
            a_d     = gnt_a;
            b_d     = gnt_b;
            cnt_d   = LAT_L;
            state_d = ST_EXEC;
          end else begin
            data_d  = 32'd0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          data_d  = bus.alu_result;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          ptr_d   = id_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= 1'b1;
      id_q    <= 1'b0;
      sel_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.alu_select = sel_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = data_q;
  assign bus.rsp_err    = err_q;

endmodule
